qspi_flash_responder: RTL and testbench
=======================================

// Module: qspi_flash_responder
// PURPOSE
// - Flash-side responder for the QSPI XIP link: decodes the cmd/addr/dummy sequence issued by the
//   QSPI controller and returns read data on the IO lines from a byte-wide memory port.
// - Serves as the synthesizable flash model in the subsystem bench and as a loopback target on FPGA.
// - Runs on the AHB clock; sclk/cs_n/io are oversampled (h_clk >= 8x sclk). SPI mode 0 only.
// PARAMETERS
// - MEM_AW        16  byte-address width of memory port; flash address bits above MEM_AW ignored
// - DUMMY_CYCLES  6   sclk cycles between last address edge and first data edge (quad cmds only)
// PORTS
// - h_clk          in   1        system clock; sole clock of the block
// - h_rstn         in   1        asynchronous active-low reset
// - sclk_in        in   1        SPI clock from controller (async, synchronised inside)
// - cs_n_in        in   1        chip select, active low (async, synchronised inside)
// - io_in          in   4        IO line inputs io[3:0] (async, synchronised inside)
// - io_out         out  4        IO line drive values
// - io_oe          out  4        per-line output enable
// - mem_rd_en      out  1        one-cycle byte read strobe
// - mem_addr       out  MEM_AW   byte address of read
// - mem_rdata      in   8        read data, valid exactly 1 h_clk after mem_rd_en
// - addr4_mode_out out  1        1 = 4-byte address mode active
// - cmd_err_out    out  1        one-cycle pulse: unsupported opcode received
// - busy_out       out  1        1 while cs_n (synchronised) is low
// BEHAVIOUR
// - Reset: io_out=0, io_oe=0, mem_rd_en=0, mem_addr=0, addr4_mode_out=0, cmd_err_out=0, busy_out=0,
//   state IDLE, all counters 0. Async assert, sync release.
// - Sync: sclk_in, cs_n_in, io_in via 2-flop synchronisers; rise/fall detect on synced sclk.
//   Sample on detected rise, drive on detected fall; outputs lag pins by 3 h_clk.
// - States: IDLE -> CMD (cs_n low) -> ADDR -> DUMMY -> DATA; IGNORE for bad/complete opcodes.
//   cs_n high in any state -> IDLE next cycle, io_oe=0, mem_rd_en=0; partial sequence discarded.
// - CMD: 8 bits on io[0], MSB first, 1 bit per rise. Decode at 8th rise:
//   0x03 read 1-1-1, 24b addr, no dummy | 0x13 read 1-1-1, 32b addr, no dummy
//   0xEB quad read 1-4-4, 24b (32b if addr4_mode) addr, dummy | 0xEC quad read 1-4-4, 32b addr, dummy
//   0xB7 set addr4_mode=1 -> IGNORE | 0xE9 clear addr4_mode=0 -> IGNORE
//   other -> cmd_err_out pulse 1 cycle, IGNORE. Mode change takes effect at decode, held across cs_n.
// - ADDR: MSB first; single: 1 bit/rise on io[0]; quad: nibble/rise on io[3:0] (io3 = MSB).
//   24b = 24 or 6 rises; 32b = 32 or 8 rises. Bits above MEM_AW discarded.
// - DUMMY: count DUMMY_CYCLES rises, io_oe=0, data ignored.
// - Fetch: mem_rd_en pulses on the cycle after the last addr rise (quad: same, during dummy).
//   rdata latched into byte shift reg on the following cycle.
// - DATA: single -> io_oe=4'b0010, bit on io[1], MSB first, 1 bit per fall;
//   quad -> io_oe=4'b1111, high nibble first, 1 nibble per fall.
//   First bit/nibble driven on first fall after entering DATA (single: first fall after last addr rise).
//   Prefetch: mem_rd_en for addr+1 on fall that drives bit/nibble 0 of current byte; load at byte boundary.
//   Address increments per byte, wraps 2^MEM_AW-1 -> 0. Continues until cs_n high.
// - IGNORE: io_oe=0, no memory reads, wait for cs_n high.
// - Simultaneous cs_n rise and sclk edge: cs_n wins, no state update from the edge.
// - sclk edges while cs_n high ignored; busy_out = ~cs_n_sync.
// TESTING
// - Reset mid-DATA (h_rstn low 2 cycles) -> all outputs to reset values, IDLE, addr4_mode_out=0.
// - 0x03, addr 0x000010, mem[0x10]=0xA5, mem[0x11]=0x3C -> io[1] bits 1010_0101 then 0011_1100, io_oe=0010.
// - 0xEB, addr 0x001234, 6 dummy -> nibbles of mem[0x1234], mem[0x1235] on io[3:0], io_oe=1111 after 6 dummies.
// - 0xB7 then new cs_n frame 0xEB, 8-nibble addr 0x0000FFFF, 3 bytes -> mem[0xFFFF], mem[0x0000], mem[0x0001].
// - Opcode 0x9F -> cmd_err_out single pulse, io_oe=0 for rest of frame, mem_rd_en never asserted.
// - cs_n raised after 3 addr bits, new 0x03 frame -> first frame discarded, second returns correct data.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder
// Flash-side QSPI responder. It decodes the opcode, address and dummy phases that a
// QSPI controller sends, and then returns bytes read from a byte-wide memory port.
// SPI mode 0 only. All pins are oversampled on h_clk, which must be at least 8x sclk.
//
// Ports
//   h_clk, h_rstn    system clock / async active-low reset
//   sclk_in          SPI clock from the controller (async)
//   cs_n_in          chip select, active low (async)
//   io_in[3:0]       IO line inputs (async)
//   io_out, io_oe    IO line drive values and per-line output enables
//   mem_rd_en        one-cycle byte read strobe
//   mem_addr         byte address of the read
//   mem_rdata        read data, valid one h_clk after mem_rd_en
//   addr4_mode_out   4-byte address mode active
//   cmd_err_out      one-cycle pulse when an unsupported opcode is received
//   busy_out         high while the synchronised cs_n is low
module qspi_flash_responder #(
   parameter int MEM_AW       = 16,
   parameter int DUMMY_CYCLES = 6
) (
   input  logic              h_clk,
   input  logic              h_rstn,
   input  logic              sclk_in,
   input  logic              cs_n_in,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   output logic              mem_rd_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              addr4_mode_out,
   output logic              cmd_err_out,
   output logic              busy_out
);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE} state_t;

   // Two-flop synchronisers, plus one extra sclk stage for edge detection.
   logic       sclk_s1_q, sclk_s2_q, sclk_prev_q;
   logic       cs_s1_q, cs_s2_q;
   logic [3:0] io_s1_q, io_s2_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_prev_q <= 1'b0;
         cs_s1_q     <= 1'b1;   // deselected after reset, so busy_out reads 0
         cs_s2_q     <= 1'b1;
         io_s1_q     <= 4'h0;
         io_s2_q     <= 4'h0;
      end else begin
         sclk_s1_q   <= sclk_in;
         sclk_s2_q   <= sclk_s1_q;
         sclk_prev_q <= sclk_s2_q;
         cs_s1_q     <= cs_n_in;
         cs_s2_q     <= cs_s1_q;
         io_s1_q     <= io_in;
         io_s2_q     <= io_s1_q;
      end
   end

   logic sclk_rise, sclk_fall;
   assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s2_q & sclk_prev_q;

   state_t            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;        // bit/rise counter shared by all phases
   logic [5:0]        alen_q, alen_d;      // address length in sclk rises
   logic [31:0]       sr_q, sr_d;          // opcode/address shift register
   logic              quad_q, quad_d;
   logic              addr4_q, addr4_d;
   logic              cmd_err_q, cmd_err_d;
   logic              mem_rd_en_q, mem_rd_en_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic              rd_pend_q, rd_pend_d;
   logic [7:0]        buf_q, buf_d;        // prefetched next byte
   logic [7:0]        sh_q, sh_d;          // byte currently being shifted out
   logic [3:0]        io_out_q, io_out_d;
   logic [7:0]        byte_v;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alen_d      = alen_q;
      sr_d        = sr_q;
      quad_d      = quad_q;
      addr4_d     = addr4_q;
      cmd_err_d   = 1'b0;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      rd_pend_d   = mem_rd_en_q;
      buf_d       = rd_pend_q ? mem_rdata : buf_q;
      sh_d        = sh_q;
      io_out_d    = io_out_q;
      byte_v      = (cnt_q == 6'd0) ? buf_q : sh_q;

      if (cs_s2_q) begin
         // Deselect wins over any simultaneous sclk edge and drops the partial frame.
         state_d  = S_IDLE;
         cnt_d    = 6'd0;
         io_out_d = 4'h0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_CMD;
               cnt_d   = 6'd0;
               sr_d    = 32'h0;
            end
            S_CMD: if (sclk_rise) begin
               sr_d  = {sr_q[30:0], io_s2_q[0]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd7) begin
                  cnt_d = 6'd0;
                  case (sr_d[7:0])
                     8'h03: begin quad_d = 1'b0; alen_d = 6'd24; state_d = S_ADDR; end
                     8'h13: begin quad_d = 1'b0; alen_d = 6'd32; state_d = S_ADDR; end
                     8'hEB: begin
                        quad_d  = 1'b1;
                        alen_d  = addr4_q ? 6'd8 : 6'd6;
                        state_d = S_ADDR;
                     end
                     8'hEC: begin quad_d = 1'b1; alen_d = 6'd8; state_d = S_ADDR; end
                     8'hB7: begin addr4_d = 1'b1; state_d = S_IGNORE; end
                     8'hE9: begin addr4_d = 1'b0; state_d = S_IGNORE; end
                     default: begin cmd_err_d = 1'b1; state_d = S_IGNORE; end
                  endcase
               end
            end
            S_ADDR: if (sclk_rise) begin
               sr_d  = quad_q ? {sr_q[27:0], io_s2_q} : {sr_q[30:0], io_s2_q[0]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == alen_q - 6'd1) begin
                  // Flash address bits above MEM_AW simply fall off here.
                  cnt_d       = 6'd0;
                  mem_rd_en_d = 1'b1;
                  mem_addr_d  = sr_d[MEM_AW-1:0];
                  state_d     = quad_q ? S_DUMMY : S_DATA;
               end
            end
            S_DUMMY: if (sclk_rise) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(DUMMY_CYCLES - 1)) begin
                  cnt_d   = 6'd0;
                  state_d = S_DATA;
               end
            end
            S_DATA: if (sclk_fall) begin
               if (quad_q) begin
                  io_out_d = byte_v[7:4];
                  sh_d     = {byte_v[3:0], 4'h0};
                  cnt_d    = (cnt_q == 6'd1) ? 6'd0 : 6'd1;
               end else begin
                  io_out_d = {2'b00, byte_v[7], 1'b0};
                  sh_d     = {byte_v[6:0], 1'b0};
                  cnt_d    = (cnt_q == 6'd7) ? 6'd0 : cnt_q + 6'd1;
               end
               // First beat of a byte comes from the prefetch buffer; refill it now.
               if (cnt_q == 6'd0) begin
                  mem_rd_en_d = 1'b1;
                  mem_addr_d  = mem_addr_q + MEM_AW'(1);
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= 6'd0;
         alen_q      <= 6'd0;
         sr_q        <= 32'h0;
         quad_q      <= 1'b0;
         addr4_q     <= 1'b0;
         cmd_err_q   <= 1'b0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         rd_pend_q   <= 1'b0;
         buf_q       <= 8'h0;
         sh_q        <= 8'h0;
         io_out_q    <= 4'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alen_q      <= alen_d;
         sr_q        <= sr_d;
         quad_q      <= quad_d;
         addr4_q     <= addr4_d;
         cmd_err_q   <= cmd_err_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
         rd_pend_q   <= rd_pend_d;
         buf_q       <= buf_d;
         sh_q        <= sh_d;
         io_out_q    <= io_out_d;
      end
   end

   assign io_out         = io_out_q;
   assign io_oe          = (state_q == S_DATA) ? (quad_q ? 4'b1111 : 4'b0010) : 4'b0000;
   assign mem_rd_en      = mem_rd_en_q;
   assign mem_addr       = mem_addr_q;
   assign addr4_mode_out = addr4_q;
   assign cmd_err_out    = cmd_err_q;
   assign busy_out       = ~cs_s2_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// tb_qspi_flash_responder
// Drives the responder as a QSPI controller would and compares each returned byte
// against a reference model. The model tracks the address mode and reads
// bench-owned memory at (start + i) mod 2^16.
module tb_qspi_flash_responder;

   logic        h_clk = 1'b0;
   logic        h_rstn;
   logic        sclk_in;
   logic        cs_n_in;
   logic [3:0]  io_in;
   logic [3:0]  io_out;
   logic [3:0]  io_oe;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        addr4_mode_out;
   logic        cmd_err_out;
   logic        busy_out;

   int n_cmp = 0;
   int n_err = 0;
   int rd_cnt = 0;
   int err_cnt = 0;
   bit model_addr4 = 1'b0;

   logic [7:0] mem [0:65535];

   qspi_flash_responder #(.MEM_AW(16), .DUMMY_CYCLES(6)) dut (
      .h_clk(h_clk), .h_rstn(h_rstn), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
      .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .addr4_mode_out(addr4_mode_out),
      .cmd_err_out(cmd_err_out), .busy_out(busy_out)
   );

   always #5 h_clk = ~h_clk;

   always @(posedge h_clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      if (mem_rd_en) rd_cnt++;
      if (cmd_err_out) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One sclk period: set io while low, sample outputs just before the rise.
   task automatic sclk_cycle(input logic [3:0] io_v, output logic [3:0] s_io,
                             output logic [3:0] s_oe);
      io_in = io_v;
      #50;
      s_io = io_out;
      s_oe = io_oe;
      #10 sclk_in = 1'b1;
      #60 sclk_in = 1'b0;
   endtask

   task automatic send_single(input logic [31:0] v, input int nbits);
      logic [3:0] s_io, s_oe;
      for (int i = nbits - 1; i >= 0; i--) sclk_cycle({3'b000, v[i]}, s_io, s_oe);
   endtask

   task automatic send_quad(input logic [31:0] v, input int nnib);
      logic [3:0] s_io, s_oe;
      for (int i = nnib - 1; i >= 0; i--) sclk_cycle(v[i*4 +: 4], s_io, s_oe);
   endtask

   task automatic frame_begin();
      cs_n_in = 1'b0;
      #100;
   endtask

   task automatic frame_end();
      #100 cs_n_in = 1'b1;
      #200;
   endtask

   task automatic read_bytes(input logic [31:0] addr, input int n, input bit quad,
                             input string tag);
      logic [3:0] s_io, s_oe, oe_first;
      logic [7:0] got;
      logic [15:0] a;
      for (int b = 0; b < n; b++) begin
         got = 8'h00;
         oe_first = 4'h0;
         for (int k = 0; k < (quad ? 2 : 8); k++) begin
            sclk_cycle(4'h0, s_io, s_oe);
            if (k == 0) oe_first = s_oe;
            got = quad ? {got[3:0], s_io} : {got[6:0], s_io[1]};
         end
         a = addr[15:0] + 16'(b);
         check($sformatf("%s byte%0d @%04h", tag, b, a), {24'h0, got}, {24'h0, mem[a]});
         check($sformatf("%s oe%0d", tag, b), {28'h0, oe_first}, quad ? 32'hF : 32'h2);
      end
   endtask

   task automatic do_read(input logic [7:0] cmd, input logic [31:0] addr, input int n,
                          input string tag);
      bit quad, a32;
      logic [3:0] s_io, s_oe;
      quad = (cmd == 8'hEB) || (cmd == 8'hEC);
      a32  = (cmd == 8'h13) || (cmd == 8'hEC) || ((cmd == 8'hEB) && model_addr4);
      frame_begin();
      send_single({24'h0, cmd}, 8);
      if (quad) send_quad(addr, a32 ? 8 : 6);
      else      send_single(addr, a32 ? 32 : 24);
      if (quad) repeat (6) sclk_cycle(4'h0, s_io, s_oe);
      read_bytes(addr, n, quad, tag);
      frame_end();
   endtask

   task automatic mode_cmd(input logic [7:0] cmd);
      frame_begin();
      send_single({24'h0, cmd}, 8);
      send_single(32'h0, 4);
      frame_end();
      model_addr4 = (cmd == 8'hB7);
      check($sformatf("addr4 after %02h", cmd), {31'h0, addr4_mode_out}, {31'h0, model_addr4});
   endtask

   initial begin
      logic [3:0] s_io, s_oe, oe_or;
      int rd0, err0;
      logic [7:0] rcmd;
      logic [31:0] raddr;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'h3C;

      h_rstn = 1'b0; sclk_in = 1'b0; cs_n_in = 1'b1; io_in = 4'h0;
      #30;
      check("rst io_out", {28'h0, io_out}, 32'h0);
      check("rst io_oe", {28'h0, io_oe}, 32'h0);
      check("rst rd_en/err/busy/a4", {28'h0, mem_rd_en, cmd_err_out, busy_out, addr4_mode_out}, 32'h0);
      check("rst mem_addr", {16'h0, mem_addr}, 32'h0);
      #10 h_rstn = 1'b1;
      #100;

      // Single read across two bytes, then quad read with 24-bit address.
      do_read(8'h03, 32'h0000_0010, 2, "rd03");
      do_read(8'hEB, 32'h0000_1234, 2, "rdEB");

      // 4-byte mode, quad read wrapping the top of memory.
      mode_cmd(8'hB7);
      do_read(8'hEB, 32'h0000_FFFF, 3, "rdEB4");
      mode_cmd(8'hE9);

      // Unsupported opcode: one error pulse, no reads, no drive for the whole frame.
      rd0 = rd_cnt; err0 = err_cnt; oe_or = 4'h0;
      frame_begin();
      send_single(32'h9F, 8);
      for (int i = 0; i < 16; i++) begin
         sclk_cycle(4'($urandom), s_io, s_oe);
         oe_or = oe_or | s_oe;
      end
      check("badop busy", {31'h0, busy_out}, 32'h1);
      frame_end();
      check("badop err pulses", 32'(err_cnt - err0), 32'd1);
      check("badop reads", 32'(rd_cnt - rd0), 32'd0);
      check("badop oe", {28'h0, oe_or}, 32'h0);
      check("idle busy", {31'h0, busy_out}, 32'h0);

      // Aborted frame after 3 address bits, then a clean frame.
      frame_begin();
      send_single(32'h03, 8);
      send_single(32'h5, 3);
      frame_end();
      do_read(8'h03, 32'h0000_0010, 2, "rdabort");

      // Randomised reads against the model.
      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(0, 3) == 0) mode_cmd(($urandom_range(0, 1) == 1) ? 8'hB7 : 8'hE9);
         case ($urandom_range(0, 3))
            0: rcmd = 8'h03;
            1: rcmd = 8'h13;
            2: rcmd = 8'hEB;
            default: rcmd = 8'hEC;
         endcase
         raddr = $urandom;
         if ($urandom_range(0, 2) == 0) raddr[15:0] = 16'hFFFE;
         do_read(rcmd, raddr, $urandom_range(1, 4), $sformatf("rnd%0d_%02h", t, rcmd));
      end

      // Reset in the middle of a data phase, with 4-byte mode set.
      mode_cmd(8'hB7);
      frame_begin();
      send_single(32'h03, 8);
      send_single(32'h0000_0010, 24);
      read_bytes(32'h10, 1, 1'b0, "prerst");
      h_rstn = 1'b0;
      #10;
      check("midrst io_out", {28'h0, io_out}, 32'h0);
      check("midrst io_oe", {28'h0, io_oe}, 32'h0);
      check("midrst rd_en/err/busy/a4", {28'h0, mem_rd_en, cmd_err_out, busy_out, addr4_mode_out}, 32'h0);
      check("midrst mem_addr", {16'h0, mem_addr}, 32'h0);
      #10 h_rstn = 1'b1;
      model_addr4 = 1'b0;
      frame_end();
      check("postrst addr4", {31'h0, addr4_mode_out}, 32'h0);
      do_read(8'hEB, 32'h0000_0100, 2, "postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
